// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and memory-wait FSM states.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// The MEM result is younger than the WB result, so MEM wins. x0 is never forwarded.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_rfwe,
    input  logic [4:0] wb_rd,
    input  logic       wb_rfwe,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_rfwe && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_rfwe && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-register stall/flush sequencer for the five-stage pipeline, with a
// memory-wait FSM (sticky timeout error) and a saturating stall counter.
//
// state    | meaning
// RUN      | normal flow; a data access acked in the same cycle needs no stall
// MEM_WAIT | data access outstanding; pipeline held until dmem_ack
// ERR      | access timed out; pipeline held until rst
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_rs1_re,
    input  logic             ID_rs2_re,
    input  logic [4:0]       EX_rs1,
    input  logic [4:0]       EX_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_rfwe,
    input  logic             EX_is_load,
    input  logic             EX_redirect,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_rfwe,
    input  logic [4:0]       WB_rd,
    input  logic             WB_rfwe,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             ctrl_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrl_state_t state;
    logic [7:0]  wait_cnt;
    logic        mem_hold;
    logic        load_use;

    always_comb begin
        mem_hold = ((state == RUN) && dmem_req && !dmem_ack)
                || ((state == MEM_WAIT) && !dmem_ack)
                || (state == ERR);
        load_use = EX_is_load && EX_rfwe && (EX_rd != 5'd0)
                && ((ID_rs1_re && (ID_rs1 == EX_rd)) || (ID_rs2_re && (ID_rs2 == EX_rd)));
    end

    // mem_hold freezes the redirect/load-use sources, so they are re-seen once it clears
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_hold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (EX_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            stall_cnt <= '0;
            ctrl_err  <= 1'b0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ERR;
                        ctrl_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    ctrl_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    fwd_unit u_fwd_a (
        .ex_rs    (EX_rs1),
        .mem_rd   (MEM_rd),
        .mem_rfwe (MEM_rfwe),
        .wb_rd    (WB_rd),
        .wb_rfwe  (WB_rfwe),
        .fwd_sel  (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .ex_rs    (EX_rs2),
        .mem_rd   (MEM_rd),
        .mem_rfwe (MEM_rfwe),
        .wb_rd    (WB_rd),
        .wb_rfwe  (WB_rfwe),
        .fwd_sel  (fwd_b_sel)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: cycle-by-cycle comparison against a
// behavioural model, plus literal expectations at the key points of each scenario.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
    logic             ID_rs1_re, ID_rs2_re, EX_rfwe, EX_is_load, EX_redirect;
    logic             MEM_rfwe, WB_rfwe, dmem_req, dmem_ack;
    logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             ctrl_err;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_re(ID_rs1_re), .ID_rs2_re(ID_rs2_re),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_rfwe(EX_rfwe),
        .EX_is_load(EX_is_load), .EX_redirect(EX_redirect),
        .MEM_rd(MEM_rd), .MEM_rfwe(MEM_rfwe), .WB_rd(WB_rd), .WB_rfwe(WB_rfwe),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ctrl_err(ctrl_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int fwd_model(input int rs, input int mrd, input bit mwe,
                                     input int wrd, input bit wwe);
        if (mwe && mrd != 0 && mrd == rs) return 1;
        if (wwe && wrd != 0 && wrd == rs) return 2;
        return 0;
    endfunction

    // Model: an access is "pending" after its first un-acked cycle; it errors
    // once it has been held for TIMEOUT cycles without an ack.
    bit m_pending = 1'b0;
    bit m_err     = 1'b0;
    int m_waited  = 0;
    int m_cnt     = 0;
    bit hold, lu, e_pc;

    always @(negedge clk) begin
        if (chk_en) begin
            hold = m_err || (m_pending ? !dmem_ack : (dmem_req && !dmem_ack));
            lu   = EX_is_load && EX_rfwe && EX_rd != 0 &&
                   ((ID_rs1_re && ID_rs1 == EX_rd) || (ID_rs2_re && ID_rs2 == EX_rd));
            e_pc = !rst && (hold || (!EX_redirect && lu));
            chk("m_pc_stall",    pc_stall,    e_pc);
            chk("m_ifid_stall",  ifid_stall,  e_pc);
            chk("m_idex_stall",  idex_stall,  !rst && hold);
            chk("m_exmem_stall", exmem_stall, !rst && hold);
            chk("m_ifid_flush",  ifid_flush,  rst || (!hold && EX_redirect));
            chk("m_idex_flush",  idex_flush,  rst || (!hold && (EX_redirect || lu)));
            chk("m_exmem_flush", exmem_flush, rst);
            chk("m_memwb_flush", memwb_flush, rst || hold);
            chk("m_fwd_a", fwd_a_sel, fwd_model(EX_rs1, MEM_rd, MEM_rfwe, WB_rd, WB_rfwe));
            chk("m_fwd_b", fwd_b_sel, fwd_model(EX_rs2, MEM_rd, MEM_rfwe, WB_rd, WB_rfwe));
            chk("m_ctrl_err",  ctrl_err,  m_err);
            chk("m_stall_cnt", stall_cnt, m_cnt);
            if (rst) begin
                m_pending = 0; m_err = 0; m_waited = 0; m_cnt = 0;
            end else begin
                if (e_pc && m_cnt < CNT_MAX) m_cnt++;
                if (m_err) begin
                end else if (m_pending) begin
                    if (dmem_ack) begin
                        m_pending = 0; m_waited = 0;
                    end else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) begin
                            m_err = 1; m_pending = 0;
                        end
                    end
                end else if (dmem_req && !dmem_ack) begin
                    m_pending = 1; m_waited = 1;
                end
            end
        end
    end

    task automatic idle();
        rst = 0;
        ID_rs1 = 0; ID_rs2 = 0; ID_rs1_re = 0; ID_rs2_re = 0;
        EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0; EX_rfwe = 0; EX_is_load = 0; EX_redirect = 0;
        MEM_rd = 0; MEM_rfwe = 0; WB_rd = 0; WB_rfwe = 0;
        dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        idle();
        rst = 1;
        settle();
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_memwb_flush", memwb_flush, 1);
        chk("rst_pc_stall", pc_stall, 0);
        step();
        rst = 0;
    endtask

    task automatic load_use_inputs(input int rd);
        EX_is_load = 1; EX_rfwe = 1; EX_rd = 5'(rd); ID_rs1 = 5; ID_rs1_re = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        chk_en = 1;
        reset_cycle();

        idle(); settle();
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_ctrl_err", ctrl_err, 0);
        chk("reset_exmem_flush", exmem_flush, 0);
        step();

        // load-use: one bubble
        load_use_inputs(5); settle();
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_ifid_stall", ifid_stall, 1);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_exmem_stall", exmem_stall, 0);
        step();
        idle(); settle();
        chk("lu_after_pc_stall", pc_stall, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        step();

        load_use_inputs(0); settle();
        chk("lu_x0_pc_stall", pc_stall, 0);
        chk("lu_x0_idex_flush", idex_flush, 0);
        step();

        idle(); ID_rs2 = 6; ID_rs2_re = 1; EX_is_load = 1; EX_rfwe = 1; EX_rd = 6; settle();
        chk("lu_rs2_pc_stall", pc_stall, 1);
        step();

        // redirect beats load-use
        idle(); load_use_inputs(5); EX_redirect = 1; settle();
        chk("redir_ifid_flush", ifid_flush, 1);
        chk("redir_idex_flush", idex_flush, 1);
        chk("redir_pc_stall", pc_stall, 0);
        step();
        idle(); settle();
        chk("redir_stall_cnt", stall_cnt, 2);
        step();

        // memory wait: three stalled cycles, ack on the fourth
        reset_cycle();
        idle(); dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_pc_stall", pc_stall, 1);
            chk("mw_exmem_stall", exmem_stall, 1);
            chk("mw_memwb_flush", memwb_flush, 1);
            step();
        end
        dmem_ack = 1; settle();
        chk("mw_ack_pc_stall", pc_stall, 0);
        chk("mw_ack_memwb_flush", memwb_flush, 0);
        step();
        idle(); dmem_req = 1; dmem_ack = 1; settle();
        chk("mw_single_pc_stall", pc_stall, 0);
        chk("mw_stall_cnt", stall_cnt, 3);
        step();

        // forwarding
        idle(); MEM_rd = 7; WB_rd = 7; EX_rs1 = 7; MEM_rfwe = 1; WB_rfwe = 1; settle();
        chk("fwd_a_mem", fwd_a_sel, 1);
        step();
        MEM_rfwe = 0; settle();
        chk("fwd_a_wb", fwd_a_sel, 2);
        step();
        MEM_rd = 0; MEM_rfwe = 1; EX_rs2 = 0; settle();
        chk("fwd_b_x0", fwd_b_sel, 0);
        step();
        EX_rs2 = 7; settle();
        chk("fwd_b_wb", fwd_b_sel, 2);
        step();

        // timeout, sticky error, saturation
        reset_cycle();
        idle(); dmem_req = 1;
        for (int i = 0; i < TIMEOUT; i++) begin
            settle();
            chk("to_pc_stall", pc_stall, 1);
            chk("to_ctrl_err_pre", ctrl_err, 0);
            step();
        end
        settle();
        chk("to_ctrl_err", ctrl_err, 1);
        chk("to_held", idex_stall, 1);
        step();
        dmem_ack = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("to_late_ack_stall", pc_stall, 1);
            step();
        end
        idle();
        for (int i = 0; i < 12; i++) step();
        settle();
        chk("sat_stall_cnt", stall_cnt, 15);
        step(); step();
        settle();
        chk("sat_hold_cnt", stall_cnt, 15);
        chk("sat_ctrl_err", ctrl_err, 1);
        step();
        reset_cycle();
        idle(); settle();
        chk("clr_ctrl_err", ctrl_err, 0);
        chk("clr_pc_stall", pc_stall, 0);
        chk("clr_stall_cnt", stall_cnt, 0);
        step();

        // reset in the middle of a wait returns to RUN
        idle(); dmem_req = 1; step(); step();
        reset_cycle();
        idle(); settle();
        chk("rst_mw_pc_stall", pc_stall, 0);
        step();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline's stage registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Produces per-register stall (hold) and flush (bubble) controls for load-use hazards, EX-stage redirects and multi-cycle data-memory accesses.
- Produces EX-stage operand forwarding selects.
- Holds a small memory-wait FSM with a timeout, plus a stall-cycle performance counter.

Parameters:
- TIMEOUT, 16, cycles in MEM_WAIT before a sticky error; range 2..255.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ID_rs1, ID_rs2  in  5  source register numbers of the instruction in ID
- ID_rs1_re, ID_rs2_re  in  1  ID instruction reads rs1 / rs2
- EX_rs1, EX_rs2  in  5  source register numbers of the instruction in EX
- EX_rd  in  5  destination register of the instruction in EX
- EX_rfwe  in  1  EX instruction writes the register file
- EX_is_load  in  1  EX instruction is a load
- EX_redirect  in  1  taken branch or jump resolved in EX
- MEM_rd, MEM_rfwe  in  5/1  destination register and write enable in MEM
- WB_rd, WB_rfwe  in  5/1  destination register and write enable in WB
- dmem_req  in  1  MEM stage is issuing a data-memory access
- dmem_ack  in  1  data memory completes the access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold the register
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load a bubble
- fwd_a_sel, fwd_b_sel  out  2  EX operand select: 0 = register file, 1 = MEM result, 2 = WB result
- ctrl_err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  count of cycles with pc_stall asserted

Behaviour:
- State: state ∈ {RUN, MEM_WAIT, ERR}; wait_cnt is 8 bits; stall_cnt.
- Reset (rst high at a clock edge): state=RUN, wait_cnt=0, stall_cnt=0, ctrl_err=0.
  - While rst is high, all stall/flush outputs are forced to 0, except ifid_flush, idex_flush, exmem_flush and memwb_flush, which are 1.
  - rst mid-MEM_WAIT or in ERR aborts the access and returns to RUN.
- Stall/flush outputs are combinational from state and inputs; there is no added latency.
- Effective conditions:
  - mem_hold = (state==RUN & dmem_req & !dmem_ack) | state==MEM_WAIT & !dmem_ack | state==ERR.
  - load_use = EX_is_load & EX_rfwe & EX_rd≠0 & ((ID_rs1_re & ID_rs1==EX_rd) | (ID_rs2_re & ID_rs2==EX_rd)).
- Priority 1, mem_hold:
  - pc_stall=ifid_stall=idex_stall=exmem_stall=1 and memwb_flush=1, so WB does not retire twice.
  - All other flushes are 0; redirect and load_use are ignored, since their sources are frozen and remain valid.
- Priority 2, EX_redirect: ifid_flush=idex_flush=1, no stalls. This overrides a simultaneous load_use, because the ID instruction is squashed.
- Priority 3, load_use: pc_stall=ifid_stall=1, idex_flush=1. This gives exactly one bubble; next cycle the load is in MEM and forwarding resolves the dependency.
- Otherwise: all outputs 0.
- FSM transitions:
  - RUN: dmem_req & !dmem_ack → MEM_WAIT with wait_cnt=1. dmem_req & dmem_ack → stay in RUN with no stall (single-cycle access).
  - MEM_WAIT: dmem_ack → RUN and wait_cnt=0; the ack cycle itself is not stalled. Otherwise wait_cnt+1. If wait_cnt==TIMEOUT-1 and there is no ack → ERR.
  - ERR: ctrl_err=1; the pipeline is held indefinitely. Only rst exits.
  - A late dmem_ack in ERR is ignored.
- Forwarding, for fwd_a with rs1 (fwd_b is identical with rs2):
  - Select 1 if MEM_rfwe & MEM_rd≠0 & MEM_rd==EX_rs1.
  - Else select 2 if WB_rfwe & WB_rd≠0 & WB_rd==EX_rs1.
  - Else select 0.
  - MEM beats WB when both match. Register x0 is never forwarded.
- stall_cnt increments by 1 each cycle pc_stall==1 and rst==0. It saturates at all-ones and never wraps.

Decomposition:
- Shared package:
  - forwarding-select constants FWD_RF=0, FWD_MEM=1, FWD_WB=2;
  - FSM state encoding RUN=0, MEM_WAIT=1, ERR=2.
- One natural sub-module, fwd_unit: purely combinational, instantiated once per operand, so twice.
- FSM, counters and stall/flush priority logic stay in the top module.

Test Plan:
- Load-use: EX_is_load=1, EX_rfwe=1, EX_rd=5, ID_rs1=5, ID_rs1_re=1 for one cycle → pc_stall=ifid_stall=idex_flush=1 for exactly one cycle; stall_cnt goes 0→1.
  - Repeat with EX_rd=0 → no stall.
- Redirect with simultaneous load_use → ifid_flush=idex_flush=1, pc_stall=0, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ack=0 for 3 cycles, then ack on cycle 4 →
  - the four stalls and memwb_flush are 1 on cycles 1–3;
  - all are 0 on cycle 4;
  - state returns to RUN; stall_cnt=3.
- Timeout: TIMEOUT=4, dmem_req=1, no ack → ERR entered after 4 stalled cycles; ctrl_err=1 and the pipeline is held.
  - A later dmem_ack has no effect. rst=1 for one cycle clears ctrl_err and flushes all stages.
- Forwarding: MEM_rd=WB_rd=EX_rs1=7, both write enables set → fwd_a_sel=1.
  - Clear MEM_rfwe → fwd_a_sel=2.
  - EX_rs2=0 with MEM_rd=0 → fwd_b_sel=0.
- Saturation: CNT_W=4 with continuous stall → stall_cnt reaches 15 and holds at 15.
